mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits between the three memory requesters (ICache fetch, LSB load, LSB store) and the byte-serial memory controller.
- Picks one request at a time, issues a one-cycle enable pulse to the controller and waits for its done pulse. It then returns the result to the winning requester.
- Handles store-over-load priority, an ICache anti-starvation counter, pipeline flush (clear) and IO back-pressure (io_buffer_full).

Parameters:
- STARVE_LIMIT, 3: consecutive LSB grants while ic_req_i is pending before ICache is forced to win the next arbitration.
- IO_BASE, 32'h00030000: addresses >= IO_BASE are IO space.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous reset, active-low
- rdy_in  in  1  global enable; when 0, all state and outputs are held
- clear  in  1  pipeline flush
- io_buffer_full  in  1  IO output buffer full
- ic_req_i  in  1  fetch request, level, held until ic_done_o
- ic_addr_i  in  32  fetch address
- ic_done_o  out  1  one-cycle pulse, ic_data_o valid
- ic_data_o  out  32  fetched word
- ld_req_i  in  1  load request, level
- ld_addr_i  in  32  load address
- ld_len_i  in  3  load length: 1, 2 or 4
- ld_done_o  out  1  one-cycle pulse
- ld_data_o  out  32  zero-extended load data
- st_req_i  in  1  store request, level
- st_addr_i  in  32  store address
- st_data_i  in  32  store data
- st_len_i  in  3  store length: 1, 2 or 4
- st_done_o  out  1  one-cycle pulse
- mc_w_en_o, mc_r_en_o, mc_ic_en_o  out  1 each  controller enables
- mc_addr_o, mc_val_o, mc_len_o  out  32/32/32  controller operands
- mc_lsb_done_i, mc_lsb_data_i  in  1/32  controller data-side done and data
- mc_ic_done_i, mc_ic_data_i  in  1/32  controller fetch-side done and data
- busy_o  out  1  state != IDLE
- grant_o  out  2  0 none, 1 ic, 2 ld, 3 st

Behaviour:
- Reset (rst_in==0 at clk edge):
  - All enables and done outputs 0; data outputs 0; mc_* operands 0.
  - grant_o=0, busy_o=0, starve counter 0, state IDLE.
  - Reset mid-transaction discards the transaction with no done pulse.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.

IDLE:
- Eligible requests:
  - st_req_i, unless (st_addr_i >= IO_BASE && io_buffer_full).
  - ld_req_i, unless (ld_addr_i >= IO_BASE && io_buffer_full).
  - ic_req_i.
- Priority is st > ld > ic.
  - Exception: when starve_cnt == STARVE_LIMIT and ic_req_i is set, ic wins.
- starve_cnt:
  - +1 (saturating) on each st/ld grant while ic_req_i is high.
  - Cleared on an ic grant or whenever ic_req_i is low.
- On a grant: latch addr/len/data into mc_*_o, set grant_o, go to ISSUE.
- No eligible request: stay in IDLE.

ISSUE (exactly one cycle):
- The matching mc_*_en_o is 1 for this cycle only, then WAIT.
- Enables are never held high across cycles, so the controller does not restart after its own Waiting state.

WAIT:
- Waits for mc_lsb_done_i (st/ld) or mc_ic_done_i (ic).
- Register the controller data.
- Pulse the matching *_done_o on the next cycle, then go to RESP.
- Latency: *_done_o is 1 cycle after the mc done input and 3 cycles + controller time after the grant.

RESP:
- One idle cycle to let the requester drop req, then IDLE with grant_o=0.

clear:
- Has priority over everything except reset.
- In ISSUE/WAIT/RESP with grant ld or ic: abort, no done pulse, go to IDLE, starve_cnt=0.
- With grant st: ignored, the store completes and st_done_o still pulses.
- In IDLE: no grant is made in that cycle.

Other rules:
- Simultaneous done and clear on a ld/ic transaction: clear wins, no done pulse.
- io_buffer_full only gates eligibility in IDLE; it never interrupts a transaction already granted.
- Lengths are forwarded unchanged and are not checked.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- When defined:
  - Adds output ports stat_ic_o, stat_ld_o, stat_st_o (32 bits each), counting completed done pulses per requester.
  - Adds stat_stall_o (32 bits), counting IDLE cycles in which a request was held back by io_buffer_full.
  - All counters wrap at 2^32, reset to 0, are not affected by clear, and freeze when rdy_in==0.
- When undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Single fetch: ic_req_i=1, ic_addr_i=0x100; mc_ic_done_i with 0x00A00093 5 cycles after mc_ic_en_o -> mc_ic_en_o high for exactly 1 cycle with mc_addr_o=0x100; ic_done_o pulses once with ic_data_o=0x00A00093.
- Priority: st, ld and ic all requesting in the same cycle -> grants in order st, ld, ic. With STARVE_LIMIT=3 and ld/st re-requesting continuously, ic is granted by its 4th arbitration at the latest.
- Flush: clear=1 during WAIT of a load at 0x2000 -> no ld_done_o pulse, state IDLE next cycle. clear=1 during a store with len 4 -> st_done_o still pulses once.
- IO back-pressure: st_addr_i=0x30000, io_buffer_full=1, ic_req_i=1 -> ic is granted first; the store is granted only after io_buffer_full drops to 0.
- Reset mid-op: rst_in=0 during WAIT of a load -> all outputs 0 on the next edge, no done pulse; after release, a fresh load completes normally.
- rdy_in=0 for 4 cycles during WAIT -> state and outputs frozen; the done pulse is delayed by exactly 4 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates the three memory requesters (ICache fetch, LSB load, LSB store)
//   onto a single byte-serial memory controller. One request is served at a
//   time: IDLE -> ISSUE (one-cycle enable) -> WAIT (controller done) ->
//   RESP (done pulse to the winner) -> IDLE.
//
// Ports
//   clk_in, rst_in (sync, active-low), rdy_in (global hold), clear (flush),
//   io_buffer_full (IO back-pressure, gates eligibility in IDLE only)
//   ic_*  : fetch request/address in, done pulse and fetched word out
//   ld_*  : load request/address/length in, done pulse and zero-extended data out
//   st_*  : store request/address/data/length in, done pulse out
//   mc_*  : controller enables and operands out, controller done/data in
//   busy_o, grant_o (0 none, 1 ic, 2 ld, 3 st)
//
// Optional build macro MEM_ARB_STATS_EN adds stat_ic_o, stat_ld_o, stat_st_o
// (completed transactions per requester) and stat_stall_o (IDLE cycles with a
// request held back by io_buffer_full).

module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter logic [31:0] IO_BASE      = 32'h00030000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        io_buffer_full,
  input  logic        ic_req_i,
  input  logic [31:0] ic_addr_i,
  output logic        ic_done_o,
  output logic [31:0] ic_data_o,
  input  logic        ld_req_i,
  input  logic [31:0] ld_addr_i,
  input  logic [2:0]  ld_len_i,
  output logic        ld_done_o,
  output logic [31:0] ld_data_o,
  input  logic        st_req_i,
  input  logic [31:0] st_addr_i,
  input  logic [31:0] st_data_i,
  input  logic [2:0]  st_len_i,
  output logic        st_done_o,
  output logic        mc_w_en_o,
  output logic        mc_r_en_o,
  output logic        mc_ic_en_o,
  output logic [31:0] mc_addr_o,
  output logic [31:0] mc_val_o,
  output logic [31:0] mc_len_o,
  input  logic        mc_lsb_done_i,
  input  logic [31:0] mc_lsb_data_i,
  input  logic        mc_ic_done_i,
  input  logic [31:0] mc_ic_data_i,
  output logic        busy_o,
  output logic [1:0]  grant_o
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_ic_o,
  output logic [31:0] stat_ld_o,
  output logic [31:0] stat_st_o,
  output logic [31:0] stat_stall_o
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_IC   = 2'd1;
  localparam logic [1:0] G_LD   = 2'd2;
  localparam logic [1:0] G_ST   = 2'd3;

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  logic [1:0]    r_state;
  logic [1:0]    r_grant;
  logic [CW-1:0] r_starve;
  logic [31:0]   r_addr;
  logic [31:0]   r_val;
  logic [31:0]   r_len;
  logic          r_ic_done;
  logic          r_ld_done;
  logic          r_st_done;
  logic [31:0]   r_ic_data;
  logic [31:0]   r_ld_data;

  logic          w_st_io;
  logic          w_ld_io;
  logic          w_st_ok;
  logic          w_ld_ok;
  logic          w_ic_force;
  logic          w_abort;
  logic          w_mc_done;
  logic [1:0]    w_pick;
  logic [31:0]   w_ld_masked;

  // A request into IO space is held back while the IO buffer is full.
  assign w_st_io    = (st_addr_i >= IO_BASE);
  assign w_ld_io    = (ld_addr_i >= IO_BASE);
  assign w_st_ok    = st_req_i && !(w_st_io && io_buffer_full);
  assign w_ld_ok    = ld_req_i && !(w_ld_io && io_buffer_full);
  assign w_ic_force = ic_req_i && (r_starve == STARVE_MAX);

  // Stores are never aborted by a flush: they are architecturally committed.
  assign w_abort   = clear && (r_grant != G_ST);
  assign w_mc_done = (r_grant == G_IC) ? mc_ic_done_i : mc_lsb_done_i;

  // Arbitration: store > load > fetch, unless fetch has been starved long
  // enough, in which case it jumps the queue. A flush blocks new grants.
  always_comb begin
    w_pick = G_NONE;
    if (clear) w_pick = G_NONE;
    else if (w_ic_force) w_pick = G_IC;
    else if (w_st_ok) w_pick = G_ST;
    else if (w_ld_ok) w_pick = G_LD;
    else if (ic_req_i) w_pick = G_IC;
  end

  // Narrow loads are returned zero-extended regardless of what the
  // controller leaves in the upper bytes.
  always_comb begin
    w_ld_masked = mc_lsb_data_i;
    case (r_len[2:0])
      3'd1:    w_ld_masked = {24'b0, mc_lsb_data_i[7:0]};
      3'd2:    w_ld_masked = {16'b0, mc_lsb_data_i[15:0]};
      default: w_ld_masked = mc_lsb_data_i;
    endcase
  end

  // Main transaction FSM, operand latches, done pulses and starvation counter.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state   <= S_IDLE;
      r_grant   <= G_NONE;
      r_starve  <= '0;
      r_addr    <= '0;
      r_val     <= '0;
      r_len     <= '0;
      r_ic_done <= 1'b0;
      r_ld_done <= 1'b0;
      r_st_done <= 1'b0;
      r_ic_data <= '0;
      r_ld_data <= '0;
    end else if (rdy_in) begin
      r_ic_done <= 1'b0;
      r_ld_done <= 1'b0;
      r_st_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick != G_NONE) begin
            r_grant <= w_pick;
            r_state <= S_ISSUE;
            case (w_pick)
              G_ST: begin
                r_addr <= st_addr_i;
                r_val  <= st_data_i;
                r_len  <= {29'b0, st_len_i};
              end
              G_LD: begin
                r_addr <= ld_addr_i;
                r_val  <= '0;
                r_len  <= {29'b0, ld_len_i};
              end
              default: begin
                r_addr <= ic_addr_i;
                r_val  <= '0;
                r_len  <= 32'd4;
              end
            endcase
            if (w_pick == G_IC) r_starve <= '0;
            else if (ic_req_i && (r_starve != STARVE_MAX)) r_starve <= r_starve + CW'(1);
          end
        end
        S_ISSUE: begin
          if (w_abort) begin
            r_state  <= S_IDLE;
            r_grant  <= G_NONE;
            r_starve <= '0;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_abort) begin
            r_state  <= S_IDLE;
            r_grant  <= G_NONE;
            r_starve <= '0;
          end else if (w_mc_done) begin
            r_state <= S_RESP;
            case (r_grant)
              G_IC: begin
                r_ic_done <= 1'b1;
                r_ic_data <= mc_ic_data_i;
              end
              G_LD: begin
                r_ld_done <= 1'b1;
                r_ld_data <= w_ld_masked;
              end
              default: r_st_done <= 1'b1;
            endcase
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= G_NONE;
          if (w_abort) r_starve <= '0;
        end
      endcase
      if (!ic_req_i) r_starve <= '0;
    end
  end

  // Enables are decoded from the ISSUE state so they last exactly one active
  // cycle; an abort in that cycle suppresses the enable so the controller
  // never starts a discarded operation.
  assign mc_w_en_o  = (r_state == S_ISSUE) && (r_grant == G_ST);
  assign mc_r_en_o  = (r_state == S_ISSUE) && (r_grant == G_LD) && !clear;
  assign mc_ic_en_o = (r_state == S_ISSUE) && (r_grant == G_IC) && !clear;

  assign mc_addr_o = r_addr;
  assign mc_val_o  = r_val;
  assign mc_len_o  = r_len;
  assign ic_done_o = r_ic_done;
  assign ic_data_o = r_ic_data;
  assign ld_done_o = r_ld_done;
  assign ld_data_o = r_ld_data;
  assign st_done_o = r_st_done;
  assign busy_o    = (r_state != S_IDLE);
  assign grant_o   = r_grant;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] r_stat_ic;
  logic [31:0] r_stat_ld;
  logic [31:0] r_stat_st;
  logic [31:0] r_stat_stall;
  logic        w_held;

  assign w_held = io_buffer_full && ((st_req_i && w_st_io) || (ld_req_i && w_ld_io));

  // Statistics: completed transactions are counted while their done pulse is
  // visible; stalls are IDLE cycles where back-pressure hid a request.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_stat_ic    <= '0;
      r_stat_ld    <= '0;
      r_stat_st    <= '0;
      r_stat_stall <= '0;
    end else if (rdy_in) begin
      if (r_ic_done) r_stat_ic <= r_stat_ic + 32'd1;
      if (r_ld_done) r_stat_ld <= r_stat_ld + 32'd1;
      if (r_st_done) r_stat_st <= r_stat_st + 32'd1;
      if ((r_state == S_IDLE) && w_held) r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_ic_o    = r_stat_ic;
  assign stat_ld_o    = r_stat_ld;
  assign stat_st_o    = r_stat_st;
  assign stat_stall_o = r_stat_stall;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed self-checking bench for mem_arbiter. The bench plays the role of
//   the three requesters and of the memory controller, and checks grants,
//   enables, operands, done pulses and returned data against hand-computed
//   values. With MEM_ARB_STATS_EN defined the statistics ports are connected.

module tb_mem_arbiter;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        io_buffer_full;
  logic        ic_req_i;
  logic [31:0] ic_addr_i;
  logic        ic_done_o;
  logic [31:0] ic_data_o;
  logic        ld_req_i;
  logic [31:0] ld_addr_i;
  logic [2:0]  ld_len_i;
  logic        ld_done_o;
  logic [31:0] ld_data_o;
  logic        st_req_i;
  logic [31:0] st_addr_i;
  logic [31:0] st_data_i;
  logic [2:0]  st_len_i;
  logic        st_done_o;
  logic        mc_w_en_o;
  logic        mc_r_en_o;
  logic        mc_ic_en_o;
  logic [31:0] mc_addr_o;
  logic [31:0] mc_val_o;
  logic [31:0] mc_len_o;
  logic        mc_lsb_done_i;
  logic [31:0] mc_lsb_data_i;
  logic        mc_ic_done_i;
  logic [31:0] mc_ic_data_i;
  logic        busy_o;
  logic [1:0]  grant_o;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_ic_o;
  logic [31:0] stat_ld_o;
  logic [31:0] stat_st_o;
  logic [31:0] stat_stall_o;
`endif

  int vectors;
  int miscompares;

  mem_arbiter #(.STARVE_LIMIT(3), .IO_BASE(32'h00030000)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .clear         (clear),
    .io_buffer_full(io_buffer_full),
    .ic_req_i      (ic_req_i),
    .ic_addr_i     (ic_addr_i),
    .ic_done_o     (ic_done_o),
    .ic_data_o     (ic_data_o),
    .ld_req_i      (ld_req_i),
    .ld_addr_i     (ld_addr_i),
    .ld_len_i      (ld_len_i),
    .ld_done_o     (ld_done_o),
    .ld_data_o     (ld_data_o),
    .st_req_i      (st_req_i),
    .st_addr_i     (st_addr_i),
    .st_data_i     (st_data_i),
    .st_len_i      (st_len_i),
    .st_done_o     (st_done_o),
    .mc_w_en_o     (mc_w_en_o),
    .mc_r_en_o     (mc_r_en_o),
    .mc_ic_en_o    (mc_ic_en_o),
    .mc_addr_o     (mc_addr_o),
    .mc_val_o      (mc_val_o),
    .mc_len_o      (mc_len_o),
    .mc_lsb_done_i (mc_lsb_done_i),
    .mc_lsb_data_i (mc_lsb_data_i),
    .mc_ic_done_i  (mc_ic_done_i),
    .mc_ic_data_i  (mc_ic_data_i),
    .busy_o        (busy_o),
    .grant_o       (grant_o)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_ic_o     (stat_ic_o),
    .stat_ld_o     (stat_ld_o),
    .stat_st_o     (stat_st_o),
    .stat_stall_o  (stat_stall_o)
`endif
  );

  // 10 time-unit clock
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Advance one active edge; outputs are observed 1 unit after the edge and
  // new inputs driven then take effect at the following edge.
  task automatic stepClock();
    @(posedge clk_in);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Set the three request levels in one go.
  task automatic applyStimulus(input logic stReq, input logic ldReq, input logic icReq);
    st_req_i = stReq;
    ld_req_i = ldReq;
    ic_req_i = icReq;
  endtask

  // From an IDLE cycle: arbitrate, issue, answer as the controller in the
  // first WAIT cycle, check the done pulse, optionally drop the winner's
  // request, and return to IDLE.
  task automatic runTxn(input string tag, input logic [1:0] expGrant,
                        input logic [31:0] data, input logic drop);
    stepClock();
    checkOutput({tag, "_grant"}, 32'(grant_o), 32'(expGrant));
    stepClock();
    if (expGrant == 2'd1) begin
      mc_ic_done_i = 1'b1;
      mc_ic_data_i = data;
    end else begin
      mc_lsb_done_i = 1'b1;
      mc_lsb_data_i = data;
    end
    stepClock();
    mc_ic_done_i  = 1'b0;
    mc_lsb_done_i = 1'b0;
    case (expGrant)
      2'd1:    checkOutput({tag, "_done"}, 32'(ic_done_o), 32'd1);
      2'd2:    checkOutput({tag, "_done"}, 32'(ld_done_o), 32'd1);
      default: checkOutput({tag, "_done"}, 32'(st_done_o), 32'd1);
    endcase
    if (drop) begin
      case (expGrant)
        2'd1:    ic_req_i = 1'b0;
        2'd2:    ld_req_i = 1'b0;
        default: st_req_i = 1'b0;
      endcase
    end
    stepClock();
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_in         = 1'b0;
    rdy_in         = 1'b1;
    clear          = 1'b0;
    io_buffer_full = 1'b0;
    ic_req_i       = 1'b0;
    ic_addr_i      = 32'h0;
    ld_req_i       = 1'b0;
    ld_addr_i      = 32'h0;
    ld_len_i       = 3'd4;
    st_req_i       = 1'b0;
    st_addr_i      = 32'h0;
    st_data_i      = 32'h0;
    st_len_i       = 3'd4;
    mc_lsb_done_i  = 1'b0;
    mc_lsb_data_i  = 32'h0;
    mc_ic_done_i   = 1'b0;
    mc_ic_data_i   = 32'h0;

    // Reset state
    stepClock();
    stepClock();
    rst_in = 1'b1;
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_grant", 32'(grant_o), 32'd0);
    checkOutput("rst_addr", mc_addr_o, 32'h0);
    checkOutput("rst_icdata", ic_data_o, 32'h0);
    checkOutput("rst_en", {29'b0, mc_w_en_o, mc_r_en_o, mc_ic_en_o}, 32'h0);

    // Single fetch, controller answers 5 cycles after the enable cycle
    ic_addr_i = 32'h100;
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepClock();
    checkOutput("fetch_en", 32'(mc_ic_en_o), 32'd1);
    checkOutput("fetch_addr", mc_addr_o, 32'h100);
    checkOutput("fetch_grant", 32'(grant_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      stepClock();
      checkOutput("fetch_en_low", 32'(mc_ic_en_o), 32'd0);
      checkOutput("fetch_nodone", 32'(ic_done_o), 32'd0);
    end
    mc_ic_done_i = 1'b1;
    mc_ic_data_i = 32'h00A00093;
    stepClock();
    mc_ic_done_i = 1'b0;
    checkOutput("fetch_done", 32'(ic_done_o), 32'd1);
    checkOutput("fetch_data", ic_data_o, 32'h00A00093);
    ic_req_i = 1'b0;
    stepClock();
    checkOutput("fetch_done_end", 32'(ic_done_o), 32'd0);
    checkOutput("fetch_idle", 32'(busy_o), 32'd0);

    // Priority st > ld > ic when all request together
    st_addr_i = 32'h200;
    st_data_i = 32'hDEADBEEF;
    st_len_i  = 3'd4;
    ld_addr_i = 32'h300;
    ld_len_i  = 3'd4;
    ic_addr_i = 32'h400;
    applyStimulus(1'b1, 1'b1, 1'b1);
    stepClock();
    checkOutput("pri_st_grant", 32'(grant_o), 32'd3);
    checkOutput("pri_st_wen", 32'(mc_w_en_o), 32'd1);
    checkOutput("pri_st_addr", mc_addr_o, 32'h200);
    checkOutput("pri_st_val", mc_val_o, 32'hDEADBEEF);
    checkOutput("pri_st_len", mc_len_o, 32'd4);
    stepClock();
    mc_lsb_done_i = 1'b1;
    stepClock();
    mc_lsb_done_i = 1'b0;
    checkOutput("pri_st_done", 32'(st_done_o), 32'd1);
    st_req_i = 1'b0;
    stepClock();
    runTxn("pri_ld", 2'd2, 32'h11223344, 1'b1);
    checkOutput("pri_ld_data", ld_data_o, 32'h11223344);
    runTxn("pri_ic", 2'd1, 32'h00000013, 1'b1);

    // Starvation: st and ld keep requesting; ic must win the 4th arbitration
    applyStimulus(1'b1, 1'b1, 1'b1);
    runTxn("stv1", 2'd3, 32'h0, 1'b0);
    runTxn("stv2", 2'd3, 32'h0, 1'b0);
    runTxn("stv3", 2'd3, 32'h0, 1'b0);
    runTxn("stv4", 2'd1, 32'h12345678, 1'b1);
    checkOutput("stv4_data", ic_data_o, 32'h12345678);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Flush during WAIT of a load at 0x2000
    ld_addr_i = 32'h2000;
    ld_len_i  = 3'd4;
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepClock();
    checkOutput("flush_ld_ren", 32'(mc_r_en_o), 32'd1);
    checkOutput("flush_ld_addr", mc_addr_o, 32'h2000);
    stepClock();
    clear = 1'b1;
    stepClock();
    clear    = 1'b0;
    ld_req_i = 1'b0;
    checkOutput("flush_ld_busy", 32'(busy_o), 32'd0);
    checkOutput("flush_ld_grant", 32'(grant_o), 32'd0);
    checkOutput("flush_ld_nodone", 32'(ld_done_o), 32'd0);
    stepClock();
    checkOutput("flush_ld_nodone2", 32'(ld_done_o), 32'd0);

    // Flush coinciding with the controller done of a load: flush wins
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepClock();
    stepClock();
    clear         = 1'b1;
    mc_lsb_done_i = 1'b1;
    mc_lsb_data_i = 32'hFFFFFFFF;
    stepClock();
    clear         = 1'b0;
    mc_lsb_done_i = 1'b0;
    ld_req_i      = 1'b0;
    checkOutput("flushdone_nodone", 32'(ld_done_o), 32'd0);
    checkOutput("flushdone_busy", 32'(busy_o), 32'd0);
    checkOutput("flushdone_data", ld_data_o, 32'h11223344);
    stepClock();

    // Flush during a store: ignored, store completes
    st_addr_i = 32'h500;
    st_data_i = 32'hCAFEF00D;
    st_len_i  = 3'd4;
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepClock();
    checkOutput("flush_st_grant", 32'(grant_o), 32'd3);
    stepClock();
    clear = 1'b1;
    stepClock();
    checkOutput("flush_st_busy", 32'(busy_o), 32'd1);
    checkOutput("flush_st_grant2", 32'(grant_o), 32'd3);
    mc_lsb_done_i = 1'b1;
    stepClock();
    mc_lsb_done_i = 1'b0;
    clear         = 1'b0;
    st_req_i      = 1'b0;
    checkOutput("flush_st_done", 32'(st_done_o), 32'd1);
    stepClock();
    checkOutput("flush_st_done_end", 32'(st_done_o), 32'd0);
    checkOutput("flush_st_idle", 32'(busy_o), 32'd0);

    // IO back-pressure: IO store held back, fetch goes first
    st_addr_i      = 32'h00030000;
    st_data_i      = 32'h000000AB;
    st_len_i       = 3'd1;
    ic_addr_i      = 32'h600;
    io_buffer_full = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    runTxn("io_ic", 2'd1, 32'h00000093, 1'b1);
    stepClock();
    checkOutput("io_held", 32'(busy_o), 32'd0);
    stepClock();
    checkOutput("io_held2", 32'(busy_o), 32'd0);
    io_buffer_full = 1'b0;
    stepClock();
    checkOutput("io_st_grant", 32'(grant_o), 32'd3);
    checkOutput("io_st_addr", mc_addr_o, 32'h00030000);
    checkOutput("io_st_len", mc_len_o, 32'd1);
    stepClock();
    mc_lsb_done_i = 1'b1;
    stepClock();
    mc_lsb_done_i = 1'b0;
    checkOutput("io_st_done", 32'(st_done_o), 32'd1);
    st_req_i = 1'b0;
    stepClock();

    // Byte load is zero-extended
    ld_addr_i = 32'h700;
    ld_len_i  = 3'd1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    runTxn("ld_byte", 2'd2, 32'hAABBCCDD, 1'b1);
    checkOutput("ld_byte_data", ld_data_o, 32'h000000DD);

    // Reset during WAIT of a load, then a fresh halfword load
    ld_addr_i = 32'h800;
    ld_len_i  = 3'd4;
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepClock();
    stepClock();
    rst_in = 1'b0;
    stepClock();
    checkOutput("rstop_busy", 32'(busy_o), 32'd0);
    checkOutput("rstop_grant", 32'(grant_o), 32'd0);
    checkOutput("rstop_addr", mc_addr_o, 32'h0);
    checkOutput("rstop_lddata", ld_data_o, 32'h0);
    checkOutput("rstop_nodone", 32'(ld_done_o), 32'd0);
    rst_in   = 1'b1;
    ld_len_i = 3'd2;
    runTxn("rstop_ld", 2'd2, 32'hAABBCCDD, 1'b1);
    checkOutput("rstop_ld_data", ld_data_o, 32'h0000CCDD);

    // rdy_in low for 4 cycles in WAIT delays the done pulse by 4 cycles
    ld_addr_i = 32'h900;
    ld_len_i  = 3'd4;
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepClock();
    checkOutput("rdy_grant", 32'(grant_o), 32'd2);
    stepClock();
    rdy_in        = 1'b0;
    mc_lsb_done_i = 1'b1;
    mc_lsb_data_i = 32'h55667788;
    for (int i = 0; i < 4; i++) begin
      stepClock();
      checkOutput("rdy_frozen_done", 32'(ld_done_o), 32'd0);
      checkOutput("rdy_frozen_busy", 32'(busy_o), 32'd1);
    end
    rdy_in = 1'b1;
    stepClock();
    mc_lsb_done_i = 1'b0;
    checkOutput("rdy_done", 32'(ld_done_o), 32'd1);
    checkOutput("rdy_data", ld_data_o, 32'h55667788);
    ld_req_i = 1'b0;
    stepClock();
    checkOutput("rdy_done_end", 32'(ld_done_o), 32'd0);
    checkOutput("rdy_idle", 32'(busy_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
